// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] EXC_VECTOR = 64'hD8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Misaligned or beyond the array; the full word index is compared so high bits never wrap.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
  endfunction
endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x 32 instruction storage, synchronous write, asynchronous read
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [INSTR_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [INSTR_W-1:0]       rd_data
);
  logic [INSTR_W-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset so a program loaded during reset survives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - memory-side responder for the fetch address/instruction interface
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [INSTR_W-1:0]       resp_instr,
  output logic                     resp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_idx,
  input  logic [INSTR_W-1:0]       prog_data
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                accept, load;
  logic [ADDR_W-1:0]   load_addr;
  logic [IW-1:0]       rd_idx;
  logic [INSTR_W-1:0]  rd_data, rd_word;
  logic                load_err;

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we      (prog_we),
    .wr_idx  (prog_idx),
    .wr_data (prog_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // With zero wait states the response is loaded on the accepting edge straight from req_addr.
  assign load_addr = (state == IDLE) ? req_addr : addr_q;
  assign rd_idx    = load_addr[IW+1:2];
  assign rd_word   = (prog_we && prog_idx == rd_idx) ? prog_data : rd_data;
  assign load_err  = addr_bad(load_addr, DEPTH);

  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = RESP;
            load       = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          state_next = RESP;
          load       = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // req_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      req_ready  <= 1'b0;
      resp_instr <= '0;
      resp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
      if (accept) begin
        addr_q <= req_addr;
      end
      if (load) begin
        resp_instr <= load_err ? '0 : rd_word;
        resp_err   <= load_err;
      end
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0)
module tb_imem_responder;
  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready, resp_err;
  logic [63:0] req_addr;
  logic [31:0] resp_instr;
  logic        prog_we;
  logic [5:0]  prog_idx;
  logic [31:0] prog_data;

  logic        z_req_valid, z_req_ready, z_resp_valid, z_resp_ready, z_resp_err;
  logic [63:0] z_req_addr;
  logic [31:0] z_resp_instr;

  int passed = 0;
  int total  = 0;

  logic [5:0]  pidx [5] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd54};
  logic [31:0] pdat [5] = '{32'h91000421, 32'h8B020023, 32'hF8000001, 32'hB4000040, 32'hD65F03C0};
  logic [31:0] exp0 [4] = '{32'h91000421, 32'h8B020023, 32'hF8000001, 32'hB4000040};

  imem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_err(resp_err), .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data)
  );

  imem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .flush(1'b0), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_instr(z_resp_instr),
    .resp_err(z_resp_err), .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accepting edge counts as edge 1; with WAIT_CYCLES=2 resp_valid is seen after the third edge.
  task automatic request(input string tag, input logic [63:0] addr, input logic [31:0] ei, input logic ee);
    req_valid = 1'b1;
    req_addr  = addr;
    tick;
    req_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(resp_valid), 64'd0);
    tick;
    chk({tag, "_lat2"}, 64'(resp_valid), 64'd0);
    tick;
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_instr"}, 64'(resp_instr), 64'(ei));
    chk({tag, "_err"}, 64'(resp_err), 64'(ee));
    chk({tag, "_busy"}, 64'(req_ready), 64'd0);
    tick;
    chk({tag, "_done"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int   acc, nresp;
    logic fire;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b1;
    prog_we = 1'b0; prog_idx = '0; prog_data = '0;
    z_req_valid = 1'b0; z_req_addr = '0; z_resp_ready = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_instr", 64'(resp_instr), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);

    for (int i = 0; i < 5; i++) begin
      prog_we = 1'b1; prog_idx = pidx[i]; prog_data = pdat[i];
      tick;
    end
    prog_we = 1'b0;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    reset = 1'b1;
    chk("ready_before_edge", 64'(req_ready), 64'd0);
    tick;
    chk("ready_after_edge", 64'(req_ready), 64'd1);

    request("a0", 64'h0, 32'h91000421, 1'b0);
    request("a4", 64'h4, 32'h8B020023, 1'b0);
    request("mis6", 64'h6, 32'h0, 1'b1);
    request("oor100", 64'h100, 32'h0, 1'b1);
    request("oor_hi", 64'h8000_0000_0000_0000, 32'h0, 1'b1);
    request("exc", 64'hD8, 32'hD65F03C0, 1'b0);

    // Backpressure: the response must hold for five stalled cycles.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 64'h8;
    tick; req_valid = 1'b0;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_instr", 64'(resp_instr), 64'hF8000001);
      chk("bp_ready", 64'(req_ready), 64'd0);
      if (i < 4) tick;
    end
    resp_ready = 1'b1;
    tick;
    chk("bp_done", 64'(resp_valid), 64'd0);
    chk("bp_ready_back", 64'(req_ready), 64'd1);

    // Flush in WAIT, then a fresh request to 0x0.
    req_valid = 1'b1; req_addr = 64'h8;
    tick; req_valid = 1'b0;
    flush = 1'b1;
    tick; flush = 1'b0;
    chk("fl_valid", 64'(resp_valid), 64'd0);
    chk("fl_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = 64'h0;
    tick; req_valid = 1'b0;
    tick;
    chk("fl_lat", 64'(resp_valid), 64'd0);
    tick;
    chk("fl_valid2", 64'(resp_valid), 64'd1);
    chk("fl_instr", 64'(resp_instr), 64'h91000421);
    tick;
    nresp = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) nresp++;
      tick;
    end
    chk("fl_no_stale", 64'(nresp), 64'd0);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
    tick;
    chk("fl_idle_ready", 64'(req_ready), 64'd1);
    flush = 1'b0; req_valid = 1'b0;
    tick; tick;
    chk("fl_idle_none", 64'(resp_valid), 64'd0);

    // Program write during WAIT is visible; write on the load edge wins.
    req_valid = 1'b1; req_addr = 64'hC;
    tick; req_valid = 1'b0;
    prog_we = 1'b1; prog_idx = 6'd3; prog_data = 32'hAAAA5555;
    tick; prog_we = 1'b0;
    tick;
    chk("wr_wait", 64'(resp_instr), 64'hAAAA5555);
    tick;
    req_valid = 1'b1; req_addr = 64'hC;
    tick; req_valid = 1'b0;
    tick;
    prog_we = 1'b1; prog_idx = 6'd3; prog_data = 32'hB4000040;
    tick; prog_we = 1'b0;
    chk("wr_load_edge", 64'(resp_instr), 64'hB4000040);
    tick;

    // Async reset in WAIT, then in RESP.
    req_valid = 1'b1; req_addr = 64'h4;
    tick; req_valid = 1'b0;
    tick;
    #3 reset = 1'b0;
    #1;
    chk("arst_wait_valid", 64'(resp_valid), 64'd0);
    chk("arst_wait_ready", 64'(req_ready), 64'd0);
    tick; reset = 1'b1;
    tick;
    chk("arst_wait_rel", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = 64'h4;
    tick; req_valid = 1'b0;
    tick; tick;
    chk("arst_resp_pre", 64'(resp_valid), 64'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_resp_instr", 64'(resp_instr), 64'd0);
    tick; reset = 1'b1;
    tick;
    chk("arst_lost", 64'(resp_valid), 64'd0);
    request("after_rst", 64'hC, 32'hB4000040, 1'b0);

    // Zero wait states: ten back-to-back requests in twenty cycles.
    acc = 0; nresp = 0;
    z_req_valid = 1'b1; z_req_addr = 64'h0;
    for (int c = 0; c < 20; c++) begin
      fire = z_req_valid && z_req_ready;
      tick;
      if (c == 0) chk("w0_latency", 64'(z_resp_valid), 64'd1);
      if (fire) begin
        acc++;
        if (acc == 10) z_req_valid = 1'b0;
        else z_req_addr = 64'(acc % 4) * 64'd4;
      end
      if (z_resp_valid) begin
        chk("w0_instr", 64'(z_resp_instr), 64'(exp0[nresp % 4]));
        chk("w0_err", 64'(z_resp_err), 64'd0);
        nresp++;
      end
    end
    chk("w0_accepts", 64'(acc), 64'd10);
    chk("w0_responses", 64'(nresp), 64'd10);
    chk("w0_idle", 64'(z_req_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch-stage address/instruction interface.
- Accepts a 64-bit byte address from fetch and returns the 32-bit instruction word after a configurable number of wait states.
- Backing store is an internal word array, loaded through a program port by bench/boot logic before reset release.
- One outstanding request; fetch can abort an in-flight request on a branch or exception redirect.

Parameters:
- DEPTH, 64, number of 32-bit instruction words (word index = addr[63:2]).
- WAIT_CYCLES, 2, cycles between request acceptance and response valid; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch presents an address.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  byte address (the fetch PC).
- flush  in  1  abort any in-flight request; its response is never delivered.
- resp_valid  out  1  instruction available.
- resp_ready  in  1  fetch consumes the response.
- resp_instr  out  32  instruction word.
- resp_err  out  1  response is for a misaligned or out-of-range address.
- prog_we  in  1  program-port write enable.
- prog_idx  in  $clog2(DEPTH)  program-port word index.
- prog_data  in  32  program-port write data.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, req_ready=0, resp_valid=0, resp_instr=0, resp_err=0, wait counter=0.
  - The memory array is not cleared.
  - req_ready rises on the first clk edge after reset deasserts.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid & req_ready at a clk edge; req_addr is captured. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle. At counter==0, load the response registers and go to RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs hold stable until resp_valid & resp_ready at a clk edge, then go to IDLE.
- Latency: resp_valid asserts exactly WAIT_CYCLES+1 edges after the accepting edge. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Error rules:
  - addr[1:0]!=0 → resp_err=1, resp_instr=0.
  - addr[63:2]>=DEPTH → resp_err=1, resp_instr=0.
  - Otherwise resp_err=0 and resp_instr=mem[addr[63:2]].
  - The error check uses all 64 address bits; no wrap-around of the index.
- Memory read: data is sampled when the response registers are loaded, not at acceptance.
  - A prog_we to the same index during WAIT is therefore visible in the response.
  - A prog_we on the load edge itself writes first (write-before-read).
- flush:
  - Level-sensitive, has priority over all other transitions.
  - In WAIT or RESP: next state IDLE, resp_valid=0 next cycle, the captured request is discarded.
  - In IDLE with req_valid=1 on the same edge: the request is NOT accepted.
  - flush & resp_valid & resp_ready on the same edge: treated as a flush; fetch must ignore that beat.
- prog_we is honoured in every state, including while a request is in flight. Writing while reset=0 is also legal (synchronous write, clk edge).
- Reset mid-operation: an immediate return to the reset values; the pending request is lost.
- resp_ready may be held high permanently. resp_valid never depends combinationally on resp_ready.

Decomposition:
- Shared package imem_pkg:
  - typedef state_t {IDLE, WAIT, RESP}.
  - constant INSTR_W=32, ADDR_W=64.
  - constant EXC_VECTOR=64'hD8, for bench use.
- One natural sub-module: imem_array, the DEPTH×32 storage with one synchronous write port and one asynchronous read port.
- FSM and counter stay in imem_responder.

Test Plan:
- Load mem[0..3]=0x91000421,0x8B020023,0xF8000001,0xB4000040; WAIT_CYCLES=2; request addr 0x0, resp_ready=1 → resp_valid on edge 3 after acceptance with resp_instr=0x91000421, resp_err=0; then addr 0x4 → 0x8B020023.
- Misaligned addr 0x6 → resp_err=1, resp_instr=0. Out-of-range addr 0x100 with DEPTH=64 → resp_err=1. Addr 0xD8 (index 54) → returns mem[54], resp_err=0.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid and resp_instr held stable, req_ready=0 throughout; the response completes on the first edge with resp_ready=1.
- Flush during WAIT (addr 0x8) with a new request to 0x0 on the next cycle → no response for 0x8; the only response returned is mem[0].
- WAIT_CYCLES=0 → resp_valid one edge after acceptance; 10 back-to-back requests complete in 20 cycles.
- Assert reset=0 asynchronously in WAIT → resp_valid=0 and req_ready=0 immediately (mid-cycle); after release, a new request for 0xC returns 0xB4000040.
